// File: rtl/alu_issue_ctrl_pkg.sv
// Shared constants for the ALU issue controller: ALUctl codes,
// MIPS opcode/funct values and the issue FSM state type.
package alu_issue_ctrl_pkg;

    localparam logic [3:0] CTL_AND = 4'b0000;
    localparam logic [3:0] CTL_OR  = 4'b0001;
    localparam logic [3:0] CTL_ADD = 4'b0010;
    localparam logic [3:0] CTL_SUB = 4'b0110;
    localparam logic [3:0] CTL_SLT = 4'b0111;
    localparam logic [3:0] CTL_NOR = 4'b1100;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;

    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_NOR = 6'b100111;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DECODE,
        ST_EXEC,
        ST_DONE
    } state_e;

endpackage

// File: rtl/alu.sv
// Combinational ALU: A, B, ALUctl -> ALUout, Zero.
// Ports: A/B operands, ALUctl op code, ALUout result, Zero flag.
module alu #(
    parameter int W = 32
) (
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    input  logic [3:0]   ALUctl,
    output logic [W-1:0] ALUout,
    output logic         Zero
);
    import alu_issue_ctrl_pkg::*;

    logic lt;

    assign lt = $signed(A) < $signed(B);

    always_comb begin
        ALUout = '0;
        case (ALUctl)
            CTL_AND: ALUout = A & B;
            CTL_OR:  ALUout = A | B;
            CTL_ADD: ALUout = A + B;
            CTL_SUB: ALUout = A - B;
            CTL_SLT: ALUout = {{(W-1){1'b0}}, lt};
            CTL_NOR: ALUout = ~(A | B);
            default: ALUout = '0;
        endcase
    end

    assign Zero = (ALUout == '0);

endmodule

// File: rtl/alu_issue_decode.sv
// Instruction decoder: opcode + low 16 bits -> ALUctl, B select,
// extended immediate, branch kind and illegal flag. Purely combinational.
module alu_issue_decode #(
    parameter int W = 32
) (
    input  logic [5:0]   op_i,
    input  logic [15:0]  imm_i,
    output logic [3:0]   alu_ctl_o,
    output logic         b_sel_o,
    output logic [W-1:0] imm_ext_o,
    output logic         is_beq_o,
    output logic         is_bne_o,
    output logic         illegal_o
);
    import alu_issue_ctrl_pkg::*;

    logic sext;

    always_comb begin
        alu_ctl_o = CTL_AND;
        b_sel_o   = 1'b0;
        sext      = 1'b0;
        is_beq_o  = 1'b0;
        is_bne_o  = 1'b0;
        illegal_o = 1'b0;
        case (op_i)
            OP_RTYPE: begin
                // funct sits in imm[5:0]; rd/shamt bits are don't-care
                case (imm_i[5:0])
                    FN_AND:  alu_ctl_o = CTL_AND;
                    FN_OR:   alu_ctl_o = CTL_OR;
                    FN_ADD:  alu_ctl_o = CTL_ADD;
                    FN_SUB:  alu_ctl_o = CTL_SUB;
                    FN_SLT:  alu_ctl_o = CTL_SLT;
                    FN_NOR:  alu_ctl_o = CTL_NOR;
                    default: illegal_o = 1'b1;
                endcase
            end
            OP_ADDI: begin
                alu_ctl_o = CTL_ADD;
                b_sel_o   = 1'b1;
                sext      = 1'b1;
            end
            OP_ANDI: begin
                alu_ctl_o = CTL_AND;
                b_sel_o   = 1'b1;
            end
            OP_ORI: begin
                alu_ctl_o = CTL_OR;
                b_sel_o   = 1'b1;
            end
            OP_SLTI: begin
                alu_ctl_o = CTL_SLT;
                b_sel_o   = 1'b1;
                sext      = 1'b1;
            end
            OP_BEQ: begin
                alu_ctl_o = CTL_SUB;
                is_beq_o  = 1'b1;
            end
            OP_BNE: begin
                alu_ctl_o = CTL_SUB;
                is_bne_o  = 1'b1;
            end
            default: illegal_o = 1'b1;
        endcase
    end

    assign imm_ext_o = sext ? W'($signed(imm_i)) : W'(imm_i);

endmodule

// File: rtl/alu_issue_ctrl.sv
// ALU issue controller: accepts instr + operands, drives the external ALU for
// one cycle, returns result/branch/illegal via a valid/ready output handshake.
// Ports: clk, rst (async high); in_valid/in_ready, instr, rs_val, rt_val;
// alu_a/alu_b/alu_ctl to ALU, alu_out/alu_zero back; out_valid/out_ready,
// result, branch_taken, illegal; ops_done output handshake counter.
module alu_issue_ctrl #(
    parameter int W     = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    input  logic [W-1:0]     rs_val,
    input  logic [W-1:0]     rt_val,
    output logic [W-1:0]     alu_a,
    output logic [W-1:0]     alu_b,
    output logic [3:0]       alu_ctl,
    input  logic [W-1:0]     alu_out,
    input  logic             alu_zero,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     result,
    output logic             branch_taken,
    output logic             illegal,
    output logic [CNT_W-1:0] ops_done
);
    import alu_issue_ctrl_pkg::*;

    state_e state_q, state_d;

    logic [5:0]       op_q;
    logic [15:0]      imm_q;
    logic [W-1:0]     rs_q, rt_q;
    logic [W-1:0]     alu_a_q, alu_b_q;
    logic [3:0]       alu_ctl_q;
    logic             illegal_q;
    logic [W-1:0]     result_q;
    logic             branch_q;
    logic [CNT_W-1:0] cnt_q;

    logic [3:0]   dec_ctl;
    logic         dec_bsel;
    logic [W-1:0] dec_imm;
    logic         dec_beq, dec_bne, dec_ill;

    logic accept, fire_out;
    logic unused_instr;

    // rs/rt register numbers are resolved upstream; only op and low half matter
    assign unused_instr = ^instr[25:16];

    alu_issue_decode #(.W(W)) u_dec (
        .op_i      (op_q),
        .imm_i     (imm_q),
        .alu_ctl_o (dec_ctl),
        .b_sel_o   (dec_bsel),
        .imm_ext_o (dec_imm),
        .is_beq_o  (dec_beq),
        .is_bne_o  (dec_bne),
        .illegal_o (dec_ill)
    );

    assign in_ready  = (state_q == ST_IDLE) && !rst;
    assign out_valid = (state_q == ST_DONE);
    assign accept    = in_valid && in_ready;
    assign fire_out  = out_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (accept) state_d = ST_DECODE;
            ST_DECODE: state_d = ST_EXEC;
            ST_EXEC:   state_d = ST_DONE;
            ST_DONE:   if (out_ready) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q      <= '0;
            imm_q     <= '0;
            rs_q      <= '0;
            rt_q      <= '0;
            alu_a_q   <= '0;
            alu_b_q   <= '0;
            alu_ctl_q <= '0;
            illegal_q <= 1'b0;
            result_q  <= '0;
            branch_q  <= 1'b0;
            cnt_q     <= '0;
        end else begin
            if (accept) begin
                op_q  <= instr[31:26];
                imm_q <= instr[15:0];
                rs_q  <= rs_val;
                rt_q  <= rt_val;
            end
            if (state_q == ST_DECODE) begin
                alu_ctl_q <= dec_ctl;
                alu_a_q   <= rs_q;
                alu_b_q   <= dec_bsel ? dec_imm : rt_q;
                illegal_q <= dec_ill;
            end
            // op_q is still held in EXEC, so branch kind is decoded live
            if (state_q == ST_EXEC) begin
                result_q <= illegal_q ? '0 : alu_out;
                branch_q <= !illegal_q &&
                            ((dec_beq && alu_zero) ||
                             (dec_bne && !alu_zero));
            end
            if (fire_out) cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign alu_a        = alu_a_q;
    assign alu_b        = alu_b_q;
    assign alu_ctl      = alu_ctl_q;
    assign result       = result_q;
    assign branch_taken = branch_q;
    assign illegal      = illegal_q;
    assign ops_done     = cnt_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl with the alu model: directed scenarios plus
// randomized ops checked against an instruction-level reference model.
module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] rs_val, rt_val;
    logic [31:0] alu_a, alu_b, alu_out;
    logic [3:0]  alu_ctl;
    logic        alu_zero;
    logic        out_valid, out_ready;
    logic [31:0] result;
    logic        branch_taken, illegal;
    logic [15:0] ops_done;

    int n_pass  = 0;
    int n_total = 0;
    int exp_cnt = 0;

    always #5 clk = ~clk;

    alu #(.W(32)) u_alu (
        .A      (alu_a),
        .B      (alu_b),
        .ALUctl (alu_ctl),
        .ALUout (alu_out),
        .Zero   (alu_zero)
    );

    alu_issue_ctrl #(.W(32), .CNT_W(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .instr        (instr),
        .rs_val       (rs_val),
        .rt_val       (rt_val),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_ctl      (alu_ctl),
        .alu_out      (alu_out),
        .alu_zero     (alu_zero),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .result       (result),
        .branch_taken (branch_taken),
        .illegal      (illegal),
        .ops_done     (ops_done)
    );

    function automatic logic [31:0] rtype(input logic [5:0] fn);
        return {6'd0, 5'd1, 5'd2, 5'd3, 5'd0, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op,
                                          input logic [15:0] imm);
        return {op, 5'd1, 5'd2, imm};
    endfunction

    // MIPS semantics of each supported instruction
    function automatic void ref_op(input logic [31:0] ins,
                                   input logic [31:0] a, b,
                                   output logic [31:0] r,
                                   output logic br, ill);
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [31:0] se, ze;
        op = ins[31:26];
        fn = ins[5:0];
        se = {{16{ins[15]}}, ins[15:0]};
        ze = {16'h0, ins[15:0]};
        r = 32'h0; br = 1'b0; ill = 1'b0;
        case (op)
            6'h00: case (fn)
                6'h24:   r = a & b;
                6'h25:   r = a | b;
                6'h20:   r = a + b;
                6'h22:   r = a - b;
                6'h2a:   r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                6'h27:   r = ~(a | b);
                default: ill = 1'b1;
            endcase
            6'h08: r = a + se;
            6'h0c: r = a & ze;
            6'h0d: r = a | ze;
            6'h0a: r = ($signed(a) < $signed(se)) ? 32'd1 : 32'd0;
            6'h04: begin r = a - b; br = (a == b); end
            6'h05: begin r = a - b; br = (a != b); end
            default: ill = 1'b1;
        endcase
    endfunction

    // Drives one op; lat counts cycles from accept edge to the edge where
    // the consumer first sees out_valid. hold = cycles with out_ready low.
    task automatic run_op(input logic [31:0] ins, a, b,
                          input int hold,
                          output logic [31:0] r,
                          output logic br, ill,
                          output int lat,
                          output bit stable);
        int k;
        logic [31:0] r0;
        logic b0, i0;
        @(negedge clk);
        k = 0;
        while (!in_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        in_valid = 1'b1;
        instr = ins; rs_val = a; rt_val = b;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        instr = $urandom(); rs_val = $urandom(); rt_val = $urandom();
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        r0 = result; b0 = branch_taken; i0 = illegal;
        stable = 1'b1;
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1;
            instr = $urandom();
            @(negedge clk);
            if (result !== r0 || branch_taken !== b0 || illegal !== i0 ||
                out_valid !== 1'b1 || in_ready !== 1'b0)
                stable = 1'b0;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        r = result; br = branch_taken; ill = illegal;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        exp_cnt++;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        instr = '0; rs_val = '0; rt_val = '0;
        repeat (3) @(negedge clk);
        n_total++; if (in_ready !== 1'b0) $display("FAIL rst_in_ready got %b want 0", in_ready); else n_pass++;
        n_total++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid got %b want 0", out_valid); else n_pass++;
        n_total++; if (ops_done !== 16'd0) $display("FAIL rst_ops_done got %0d want 0", ops_done); else n_pass++;
        n_total++; if ({result, alu_a, alu_b} !== 96'h0) $display("FAIL rst_regs got %h %h %h want 0", result, alu_a, alu_b); else n_pass++;
        n_total++; if ({alu_ctl, branch_taken, illegal} !== 6'h0) $display("FAIL rst_flags got %b want 0", {alu_ctl, branch_taken, illegal}); else n_pass++;
        rst = 1'b0;
        #1;
        n_total++; if (in_ready !== 1'b1) $display("FAIL rst_release_ready got %b want 1", in_ready); else n_pass++;
    endtask

    task automatic test_add();
        logic [31:0] r; logic br, ill; int lat; bit st;
        run_op(rtype(6'b100000), 32'd15, 32'd10, 0, r, br, ill, lat, st);
        n_total++; if (r !== 32'd25) $display("FAIL add_result got %0d want 25", r); else n_pass++;
        n_total++; if (ill !== 1'b0) $display("FAIL add_illegal got %b want 0", ill); else n_pass++;
        n_total++; if (lat !== 3) $display("FAIL add_latency got %0d want 3", lat); else n_pass++;
        n_total++; if (ops_done !== 16'(exp_cnt)) $display("FAIL add_ops_done got %0d want %0d", ops_done, exp_cnt); else n_pass++;
    endtask

    task automatic test_branch();
        logic [31:0] r; logic br, ill; int lat; bit st;
        run_op(rtype(6'b100010), 32'd10, 32'd10, 0, r, br, ill, lat, st);
        n_total++; if (r !== 32'd0) $display("FAIL sub_result got %0d want 0", r); else n_pass++;
        run_op(itype(6'b000100, 16'h0010), 32'd10, 32'd10, 0, r, br, ill, lat, st);
        n_total++; if (br !== 1'b1) $display("FAIL beq_taken got %b want 1", br); else n_pass++;
        run_op(itype(6'b000100, 16'h0010), 32'd5, 32'd10, 0, r, br, ill, lat, st);
        n_total++; if (br !== 1'b0) $display("FAIL beq_not_taken got %b want 0", br); else n_pass++;
        run_op(itype(6'b000101, 16'h0010), 32'd5, 32'd10, 0, r, br, ill, lat, st);
        n_total++; if (br !== 1'b1) $display("FAIL bne_taken got %b want 1", br); else n_pass++;
    endtask

    task automatic test_imm();
        logic [31:0] r; logic br, ill; int lat; bit st;
        run_op(itype(6'b001101, 16'h8000), 32'd0, 32'hDEAD, 0, r, br, ill, lat, st);
        n_total++; if (r !== 32'h0000_8000) $display("FAIL ori_zext got %h want 00008000", r); else n_pass++;
        run_op(itype(6'b001000, 16'hFFFF), 32'd0, 32'hDEAD, 0, r, br, ill, lat, st);
        n_total++; if (r !== 32'hFFFF_FFFF) $display("FAIL addi_sext got %h want ffffffff", r); else n_pass++;
    endtask

    task automatic test_illegal();
        logic [31:0] r; logic br, ill; int lat; bit st;
        run_op(itype(6'b111111, 16'h1234), 32'd7, 32'd9, 0, r, br, ill, lat, st);
        n_total++; if (ill !== 1'b1) $display("FAIL illegal_flag got %b want 1", ill); else n_pass++;
        n_total++; if (r !== 32'd0) $display("FAIL illegal_result got %h want 0", r); else n_pass++;
        n_total++; if (lat !== 3) $display("FAIL illegal_latency got %0d want 3", lat); else n_pass++;
        run_op(rtype(6'b100111), 32'hFFFF_FFFF, 32'd0, 0, r, br, ill, lat, st);
        n_total++; if (r !== 32'd0) $display("FAIL nor_result got %h want 0", r); else n_pass++;
    endtask

    task automatic test_backpressure();
        logic [31:0] r; logic br, ill; int lat; bit st;
        run_op(rtype(6'b100101), 32'hF0F0_0000, 32'h0000_0F0F, 5, r, br, ill, lat, st);
        n_total++; if (st !== 1'b1) $display("FAIL hold_stable got %b want 1", st); else n_pass++;
        n_total++; if (r !== 32'hF0F0_0F0F) $display("FAIL hold_result got %h want f0f00f0f", r); else n_pass++;
        n_total++; if (ops_done !== 16'(exp_cnt)) $display("FAIL hold_ops_done got %0d want %0d", ops_done, exp_cnt); else n_pass++;
    endtask

    task automatic test_random();
        logic [31:0] r, er, a, b, ins, rnd;
        logic br, ill, ebr, eill;
        int lat, sel, errs;
        bit st;
        logic [5:0] fns [6] = '{6'h24, 6'h25, 6'h20, 6'h22, 6'h2a, 6'h27};
        logic [5:0] ops [6] = '{6'h08, 6'h0c, 6'h0d, 6'h0a, 6'h04, 6'h05};
        errs = 0;
        for (int i = 0; i < 40; i++) begin
            sel = $urandom_range(0, 13);
            rnd = $urandom();
            a = $urandom(); b = $urandom();
            if (sel < 6)       ins = {6'd0, rnd[25:6], fns[sel]};
            else if (sel < 12) ins = {ops[sel-6], rnd[25:0]};
            else               ins = rnd;
            if ($urandom_range(0, 2) == 0) b = a;
            ref_op(ins, a, b, er, ebr, eill);
            run_op(ins, a, b, $urandom_range(0, 2), r, br, ill, lat, st);
            n_total++;
            if (r !== er || br !== ebr || ill !== eill || lat !== 3 ||
                st !== 1'b1 || ops_done !== 16'(exp_cnt)) begin
                $display("FAIL rand_op%0d ins=%h got r=%h br=%b ill=%b lat=%0d cnt=%0d want r=%h br=%b ill=%b lat=3 cnt=%0d",
                         i, ins, r, br, ill, lat, ops_done, er, ebr, eill, exp_cnt);
                errs++;
            end else n_pass++;
        end
    endtask

    task automatic test_rst_mid();
        logic [31:0] r; logic br, ill; int lat; bit st, seen;
        @(negedge clk);
        in_valid = 1'b1;
        instr = rtype(6'b100000); rs_val = 32'd1; rt_val = 32'd2;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        exp_cnt = 0;
        #1;
        n_total++; if (out_valid !== 1'b0) $display("FAIL midrst_out_valid got %b want 0", out_valid); else n_pass++;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        n_total++; if (in_ready !== 1'b1) $display("FAIL midrst_in_ready got %b want 1", in_ready); else n_pass++;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        n_total++; if (seen !== 1'b0) $display("FAIL midrst_no_valid got %b want 0", seen); else n_pass++;
        n_total++; if (ops_done !== 16'd0) $display("FAIL midrst_ops_done got %0d want 0", ops_done); else n_pass++;
        run_op(rtype(6'b101010), 32'hFFFF_FFFF, 32'd1, 0, r, br, ill, lat, st);
        n_total++; if (r !== 32'd1) $display("FAIL post_rst_slt got %h want 1", r); else n_pass++;
        n_total++; if (ops_done !== 16'd1) $display("FAIL post_rst_ops_done got %0d want 1", ops_done); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_add();
        test_branch();
        test_imm();
        test_illegal();
        test_backpressure();
        test_random();
        test_rst_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
